// File: rtl/table_writer_pkg.sv
// Shared types and default sizing for the table writer block.
package table_writer_pkg;

  // Default width of a table entry / input byte.
  localparam int DEF_DATA_WIDTH = 8;

  // Default table depth (must be a power of two).
  localparam int DEF_ITEMS = 4;

  // Controller states: zero the table, accept bytes, hold a complete table.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/table_writer_if.sv
// Write-stream handshake and read port of the table writer, bundled.
// The producer/reader side uses 'master'; the table writer uses 'slave'.
interface table_writer_if
  import table_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = 2
);

  logic [DATA_WIDTH-1:0] din_data;
  logic                  din_vld;
  logic                  din_rd;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output din_data, din_vld, rd_addr,
    input  din_rd, rd_data
  );

  modport slave (
    input  din_data, din_vld, rd_addr,
    output din_rd, rd_data
  );

endinterface

// File: rtl/table_ram_1w1r.sv
// Table storage: one synchronous write port and one registered read port.
// The array itself is not reset; the controller zeroes it after reset.
module table_ram_1w1r
  import table_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ITEMS      = DEF_ITEMS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(ITEMS)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(ITEMS)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [ITEMS];

  // Write port: store wdata at waddr when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: a same-edge write is not seen, so old content is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/table_writer.sv
// Table writer: zeroes a small table, fills it from a valid/ready byte
// stream, keeps a running modulo checksum, and exposes a 2-cycle read port.
module table_writer
  import table_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ITEMS      = DEF_ITEMS
) (
  input  logic                       clk,
  input  logic                       rst,
  table_writer_if.slave              bus,
  input  logic                       clear,
  output logic [$clog2(ITEMS):0]     fill_cnt,
  output logic                       loaded,
  output logic [DATA_WIDTH-1:0]      checksum
);

  localparam int AW = $clog2(ITEMS);
  localparam logic [AW-1:0] LAST_PTR = AW'(ITEMS - 1);
  localparam logic [AW:0]   LAST_CNT = (AW + 1)'(ITEMS - 1);

  state_t                state_r;
  state_t                state_nxt;
  logic [AW-1:0]         clr_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW:0]           fill_cnt_r;
  logic [DATA_WIDTH-1:0] checksum_r;
  logic [AW-1:0]         rd_addr_r;
  logic                  din_rd_s;
  logic                  xfer_s;
  logic                  we_s;
  logic [AW-1:0]         waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  // Unsigned add that drops the carry out of the top bit.
  function automatic logic [DATA_WIDTH-1:0] sum_mod(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Next-state and table write control; clear/reset override everything.
  always_comb begin
    state_nxt = state_r;
    din_rd_s  = 1'b0;
    we_s      = 1'b0;
    waddr_s   = clr_ptr_r;
    wdata_s   = '0;
    if (rst || clear) begin
      state_nxt = CLEAR;
    end else begin
      case (state_r)
        CLEAR: begin
          we_s = 1'b1;
          if (clr_ptr_r == LAST_PTR) begin
            state_nxt = FILL;
          end else begin
            state_nxt = CLEAR;
          end
        end
        FILL: begin
          din_rd_s = 1'b1;
          waddr_s  = wr_ptr_r;
          wdata_s  = bus.din_data;
          we_s     = bus.din_vld;
          if (bus.din_vld && (fill_cnt_r == LAST_CNT)) begin
            state_nxt = FULL;
          end else begin
            state_nxt = FILL;
          end
        end
        FULL: begin
          state_nxt = FULL;
        end
        default: begin
          state_nxt = CLEAR;
        end
      endcase
    end
  end

  assign xfer_s = din_rd_s & bus.din_vld;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Pointers, fill count and checksum; restart from zero on reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      clr_ptr_r  <= '0;
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      checksum_r <= '0;
    end else begin
      case (state_r)
        CLEAR: begin
          clr_ptr_r  <= clr_ptr_r + 1'b1;
          wr_ptr_r   <= '0;
          fill_cnt_r <= '0;
          checksum_r <= '0;
        end
        FILL: begin
          if (xfer_s) begin
            wr_ptr_r   <= wr_ptr_r + 1'b1;
            fill_cnt_r <= fill_cnt_r + 1'b1;
            checksum_r <= sum_mod(checksum_r, bus.din_data);
          end
        end
        default: begin
          clr_ptr_r <= clr_ptr_r;
        end
      endcase
    end
  end

  // First read stage: capture the read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_r <= '0;
    end else begin
      rd_addr_r <= bus.rd_addr;
    end
  end

  table_ram_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .ITEMS      (ITEMS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (rd_addr_r),
    .rdata (bus.rd_data)
  );

  assign bus.din_rd = din_rd_s;
  assign fill_cnt   = fill_cnt_r;
  assign checksum   = checksum_r;
  assign loaded     = (state_r == FULL);

endmodule

// File: doc/table_writer.md
TABLE_WRITER -- requirements
Module: table_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each table entry and input byte.
REQ-002 Parameter ITEMS, default 4, table depth; power of two; address width AW = log2(ITEMS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din_data  input  DATA_WIDTH  write-stream payload.
REQ-006 din_vld  input  1  producer has a valid byte.
REQ-007 din_rd  output  1  block accepts the byte this cycle; transfer when din_vld & din_rd.
REQ-008 clear  input  1  one-cycle request to zero the table and restart the fill.
REQ-009 rd_addr  input  AW  read-port address.
REQ-010 rd_data  output  DATA_WIDTH  table content at rd_addr, registered.
REQ-011 fill_cnt  output  AW+1  number of entries written since the last clear, 0..ITEMS.
REQ-012 loaded  output  1  high while the table holds ITEMS accepted bytes.
REQ-013 checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of all bytes accepted since the last clear.

Function
REQ-014 FSM states: CLEAR, FILL, FULL.
REQ-015 CLEAR: writes 0 to entry clr_ptr, increments clr_ptr each cycle, holds din_rd=0; after entry ITEMS-1 is written, goes to FILL with wr_ptr=0, fill_cnt=0, checksum=0.
REQ-016 FILL: din_rd=1; on transfer, writes din_data at wr_ptr, increments wr_ptr, adds din_data to checksum, and increments fill_cnt.
REQ-017 FILL -> FULL on the transfer that raises fill_cnt to ITEMS; wr_ptr wraps to 0.
REQ-018 FULL: din_rd=0, loaded=1; table and checksum are held until clear.
REQ-019 clear=1 in any state moves to CLEAR next cycle with clr_ptr=0, fill_cnt=0, checksum=0, loaded=0, din_rd=0.
REQ-020 clear=1 in CLEAR restarts the clear sequence at entry 0.
REQ-021 clear and a transfer in the same cycle: clear wins; the byte is not written, not counted, and not summed; din_rd is 0 during that cycle.
REQ-022 din_rd depends only on state and clear, never combinationally on din_vld.
REQ-023 Read latency is 2 cycles: rd_addr is registered in stage 1 and the table is read into the rd_data register in stage 2.
REQ-024 A read and a write to the same entry in the same cycle return the old content; the new value is visible to a read issued one cycle later.
REQ-025 Reads are legal in every state; during CLEAR, reads return the mix of old and zeroed entries matching the clear progress.
REQ-026 checksum addition discards the carry and uses unsigned arithmetic.

Reset
REQ-027 rst=1 forces state=CLEAR, clr_ptr=0, wr_ptr=0, fill_cnt=0, checksum=0, loaded=0, din_rd=0, and both read pipeline registers=0.
REQ-028 After rst is deasserted, the block spends ITEMS cycles in CLEAR before din_rd rises.
REQ-029 rst takes precedence over clear and transfers in the same cycle.

Structure
REQ-030 A shared package holds the state enum (CLEAR, FILL, FULL) and the default DATA_WIDTH and ITEMS constants.
REQ-031 Table storage is one sub-module, table_ram_1w1r: one synchronous write port, one registered read port, no reset on the array.
REQ-032 The FSM, pointers, counter, checksum, and read-address stage stay in table_writer.

Verification
REQ-033 Reset release: rst held 2 cycles -> din_rd=0 for exactly 4 cycles, then 1; fill_cnt=0; checksum=0.
REQ-034 Fill: send 0x11, 0x22, 0x33, 0x44 back-to-back -> loaded=1 on the cycle after the 4th transfer; checksum=0xAA; din_rd=0; reading addresses 0..3 returns 0x11..0x44, each 2 cycles after its address.
REQ-035 Overflow sum and stall: send 0xFF, 0x02, 0x80, 0x80 with din_vld gaps -> checksum=0x01; gap cycles do not change fill_cnt.
REQ-036 Clear collision: clear asserted with din_vld=1 at fill_cnt=2 -> byte dropped; 4 CLEAR cycles follow; all entries read 0x00; fill_cnt=0.
REQ-037 Read/write same entry: in FILL, write 0x5A to addr 1 while reading addr 1 -> old value returned; re-read one cycle later -> 0x5A.
REQ-038 Mid-operation reset: rst pulsed in FULL -> loaded=0 next cycle, CLEAR sequence runs, then the refill works as in REQ-034.
